// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage feeding the control/decode FSM.
//
// Owns the program counter and issues reads to a synchronous instruction
// memory (1-cycle read latency). Returned words are queued with their PCs in a
// small FIFO and handed to decode over a valid/ready handshake. A redirect
// flushes the FIFO and any response in flight, then restarts fetch at the
// target.
//
// Parameters:
//   RESET_PC   PC loaded on reset (word aligned)
//   BUF_DEPTH  instruction buffer entries (power of two, >= 2)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   imem_addr, imem_rden        read request (address = PC register)
//   imem_q                      read data, valid the cycle after imem_rden
//   redirect_valid, redirect_pc new fetch target; flushes everything in flight
//   instr_valid, instr_ready    decode handshake
//   instr, instr_pc             buffer head word and its address
//
// Optional build macro IFETCH_PERF_EN adds perf_fetched (handshakes) and
// perf_bubbles (cycles decode was ready but nothing was valid).
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rden,
  input  logic [31:0] imem_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
  localparam logic [OccW:0] DepthCnt = BUF_DEPTH[OccW:0];

  logic [31:0]     pc_q, pc_d, req_pc_q;
  logic            inflight_q;
  logic [31:0]     buf_instr_q [BUF_DEPTH];
  logic [31:0]     buf_pc_q    [BUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [OccW-1:0] occ_q, occ_d;
  logic [31:0]     last_instr_q, last_pc_q;
  logic            pop, push;
  logic [OccW:0]   pending;

  always_comb begin
    instr_valid = (occ_q != '0);
    pop         = instr_valid & instr_ready;
    // A response is dropped when a redirect lands in the same cycle.
    push        = inflight_q & ~redirect_valid;
    // Slots already committed after this cycle; the request only goes out if
    // its response is guaranteed a free entry.
    pending     = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q} - {{OccW{1'b0}}, pop};
    imem_rden   = ~reset & ~redirect_valid & (pending < DepthCnt);
    imem_addr   = pc_q;
    // When empty, the last delivered word is shown rather than a stale slot.
    instr       = instr_valid ? buf_instr_q[rd_ptr_q] : last_instr_q;
    instr_pc    = instr_valid ? buf_pc_q[rd_ptr_q]    : last_pc_q;
  end

  always_comb begin
    occ_d = occ_q;
    if (redirect_valid) begin
      occ_d = '0;
    end else if (push && !pop) begin
      occ_d = occ_q + OccW'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (imem_rden) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      last_instr_q <= '0;
      last_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_rden;
      occ_q      <= occ_d;
      if (imem_rden) begin
        req_pc_q <= pc_q;
      end
      if (pop) begin
        last_instr_q <= buf_instr_q[rd_ptr_q];
        last_pc_q    <= buf_pc_q[rd_ptr_q];
      end
      if (redirect_valid) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PtrW'(1);
        end
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      buf_instr_q[wr_ptr_q] <= imem_q;
      buf_pc_q[wr_ptr_q]    <= req_pc_q;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_bubbles <= perf_bubbles + 32'(instr_ready & ~instr_valid);
    end
  end
`endif

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the cpu control/decode FSM.
- Owns the program counter and drives read requests to the synchronous instruction memory, which has 1-cycle read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes everything in flight.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- BUF_DEPTH, 2: instruction buffer entries; power of two, >= 2.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- imem_addr, out, 32: byte address to instruction memory; equals the internal PC register.
- imem_rden, out, 1: read request this cycle; data returns on imem_q the next cycle.
- imem_q, in, 32: instruction memory read data; valid the cycle after imem_rden=1.
- redirect_valid, in, 1: load a new fetch PC and flush.
- redirect_pc, in, 32: redirect target; bits [1:0] ignored (forced to 0).
- instr_valid, out, 1: buffer head holds a valid instruction.
- instr_ready, in, 1: decode accepts the head this cycle.
- instr, out, 32: instruction word at buffer head.
- instr_pc, out, 32: address of instr.

Behaviour:
- Reset, while reset=1 at a clock edge:
  - pc=RESET_PC, buffer empty, inflight=0.
  - instr_valid=0, imem_rden=0, instr=0, instr_pc=0.
  - imem_addr=RESET_PC.
- State: pc (32b), inflight (1b, a request issued last cycle), FIFO of {instr,pc} with occupancy count 0..BUF_DEPTH.
- pop = instr_valid & instr_ready.
- issue rule, combinational: imem_rden = !reset & !redirect_valid & (occ + inflight - pop < BUF_DEPTH).
- On issue: the request carries pc; pc <= pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000; inflight <= 1. Otherwise inflight <= 0 and pc holds.
- Response: when inflight=1 and no redirect, push {imem_q, pc_of_request} into the FIFO at that edge. The issue rule guarantees the FIFO is never full when a response arrives.
- Latency: request in cycle N, data on imem_q in N+1, instr_valid=1 in N+2. First instr_valid is 2 cycles after the first request.
- Throughput: with instr_ready held at 1, one instruction per cycle in steady state.
- Output hold: while instr_valid=1 and instr_ready=0, instr and instr_pc are stable and fetch stops once occ + inflight = BUF_DEPTH.
- Redirect in cycle N, which has priority over everything:
  - A pop in cycle N still completes as a handshake.
  - The FIFO is cleared and the response arriving in N is discarded.
  - imem_rden=0 in N; pc <= {redirect_pc[31:2], 2'b00}.
  - instr_valid=0 in N+1; request to the target in N+1; target instruction valid in N+3.
- Back-to-back redirects: each restarts the sequence; only the last target is fetched.
- Simultaneous push and pop: occupancy unchanged; the head advances.
- Empty with instr_ready=1: instr_valid=0; instr/instr_pc hold their last values (don't-care to consumer).
- Reset mid-operation: in-flight data discarded; identical to power-on reset. Fetch of RESET_PC is issued in the first cycle with reset=0.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (out, 32) and perf_bubbles (out, 32), both cleared by reset and wrapping at 2^32.
  - perf_fetched increments on each pop.
  - perf_bubbles increments each cycle with instr_ready=1 and instr_valid=0.
- Undefined: ports and counters are absent; fetch behaviour is identical.

Test Plan:
- Reset release, imem preloaded with word k = 32'h1000_0000+k, instr_ready=1:
  - imem_rden=1, imem_addr=0 in cycle 0.
  - instr_valid rises in cycle 2 with instr=32'h1000_0000, instr_pc=0.
  - Thereafter one instruction per cycle, instr_pc 4, 8, 12.
- Backpressure: instr_ready=0 for 6 cycles after first valid:
  - instr and instr_pc hold at 0x1000_0000 / 0.
  - imem_rden goes 0 once occ=2.
  - On release, pcs 0, 4, 8 are delivered in order with no gaps or duplicates.
- Redirect to 32'h0000_0043 while the buffer is full:
  - Next cycle instr_valid=0 and imem_addr=32'h40.
  - Two cycles later instr_pc=32'h40; no stale pc (8, 12) ever appears.
- Redirect and pop in the same cycle:
  - The popped instr counts as accepted (perf_fetched +1 when IFETCH_PERF_EN is defined).
  - No further old-stream instruction is presented.
- PC wrap: redirect to 32'hFFFF_FFF8 with ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Reset asserted for 1 cycle mid-stream (occ=2, inflight=1):
  - Next cycle instr_valid=0, imem_addr=RESET_PC.
  - First delivered instr_pc=RESET_PC.
